pulse_stretcher: RTL

//  Output-side timing conditioner, the counterpart of the input debouncer: turns short event pulses

---
 rtl/pulse_stretcher.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pulse_stretcher.sv
// Output-side pulse conditioner: stretches short events into pulses with a
// guaranteed minimum ON time and a minimum OFF gap, measured in prescaled ticks.
module pulse_stretcher #(
  parameter int CLK_DIV = 10000,
  parameter int TW      = 8,
  parameter bit RETRIG  = 1'b0
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          ena,
  input  logic [TW-1:0] on_time,
  input  logic [TW-1:0] off_time,
  input  logic          event_in,
  output logic          data_out,
  output logic          busy,
  output logic          pending
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [TW:0]   tick_q, tick_d;
  logic [TW-1:0] limit_q, limit_d;
  logic          pend_q, pend_d;
  logic          expire;

  // The duration of the current phase is latched on entry, so later edits
  // to on_time/off_time only affect the next phase.
  assign expire = (pre_q == PRE_LAST) && (tick_q == {1'b0, limit_q});

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    limit_d = limit_q;
    if (pre_q == PRE_LAST) begin
      pre_d  = '0;
      tick_d = tick_q + 1'b1;
    end else begin
      pre_d  = pre_q + 1'b1;
      tick_d = tick_q;
    end

    case (state_q)
      S_IDLE: begin
        pre_d  = '0;
        tick_d = '0;
        if (event_in) begin
          state_d = S_ON;
          limit_d = on_time;
        end
      end
      S_ON: begin
        if (RETRIG && event_in) begin
          pre_d   = '0;
          tick_d  = '0;
          limit_d = on_time;
        end else begin
          if (event_in) pend_d = 1'b1;
          if (expire) begin
            state_d = S_GAP;
            pre_d   = '0;
            tick_d  = '0;
            limit_d = off_time;
          end
        end
      end
      S_GAP: begin
        if (expire) begin
          pre_d  = '0;
          tick_d = '0;
          if (pend_q || event_in) begin
            state_d = S_ON;
            pend_d  = 1'b0;
            limit_d = on_time;
          end else begin
            state_d = S_IDLE;
          end
        end else if (event_in) begin
          pend_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        pre_d   = '0;
        tick_d  = '0;
      end
    endcase

    // Disabling forces a clean idle so re-enabling never resumes a stale pulse.
    if (!ena) begin
      state_d = S_IDLE;
      pre_d   = '0;
      tick_d  = '0;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      tick_q  <= '0;
      limit_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      limit_q <= limit_d;
      pend_q  <= pend_d;
    end
  end

  assign data_out = ena ? (state_q == S_ON) : event_in;
  assign busy     = (state_q != S_IDLE);
  assign pending  = RETRIG ? 1'b0 : pend_q;

endmodule
